// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants and types for the sound blocks
//
// Purpose: counter width, shortest audible period, note periods (in clk
// cycles) used by the melody sequencer, and the tone generator state type.
package sound_pkg;

  localparam int CNT_W      = 22;
  localparam int MIN_PERIOD = 4;

  localparam logic [CNT_W-1:0] NOTE_DO      = 22'd191571;
  localparam logic [CNT_W-1:0] NOTE_RE      = 22'd170648;
  localparam logic [CNT_W-1:0] NOTE_MI      = 22'd151515;
  localparam logic [CNT_W-1:0] NOTE_FA      = 22'd143266;
  localparam logic [CNT_W-1:0] NOTE_SO      = 22'd127551;
  localparam logic [CNT_W-1:0] NOTE_LA      = 22'd113636;
  localparam logic [CNT_W-1:0] NOTE_SI      = 22'd101215;
  localparam logic [CNT_W-1:0] NOTE_HIGH_DO = 22'd95420;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tone_state_e;

endpackage

// File: rtl/tone_period_counter.sv
// rtl/tone_period_counter.sv - period counter with load and terminal pulse
//
// Purpose: counts 0 .. load_val_i-1 and wraps while enabled; load_i forces
// the next value to 0. cnt_next_o exposes the value the counter takes on the
// coming edge so the owner can register outputs from next-state values.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_i       restart at 0 on the next edge
//   enable_i     advance the count
//   load_val_i   period length in clk cycles
//   cnt_o        current count
//   cnt_next_o   count after the next edge
//   terminal_o   high while counting and cnt_o == load_val_i-1
module tone_period_counter #(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             terminal_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign terminal_o = enable_i && (cnt_q == load_val_i - ONE);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = terminal_o ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - glitch-free square-wave buzzer driver with duty volume
//
// Purpose: plays a square wave of period `pitch` clk cycles with high time
// (pitch*volume)>>5. Pitch and volume are latched only at period boundaries;
// dropping `en` lets the current period finish before going silent.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           tone request from the sequencer
//   pitch        full period in clk cycles (below MIN_PERIOD = silence)
//   volume       duty control, 0 = mute
//   spk_out      registered square wave
//   active       high while a tone (or its draining period) is playing
//   period_done  one-cycle pulse on the last cycle of each period
//   cur_pitch    latched period, 0 when idle
module tone_gen #(
  parameter int CNT_W      = sound_pkg::CNT_W,
  parameter int VOL_W      = 4,
  parameter int MIN_PERIOD = sound_pkg::MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] pitch,
  input  logic [VOL_W-1:0] volume,
  output logic             spk_out,
  output logic             active,
  output logic             period_done,
  output logic [CNT_W-1:0] cur_pitch
);

  import sound_pkg::*;

  localparam int               PW    = CNT_W + VOL_W;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  tone_state_e      state_q, state_d;
  logic [CNT_W-1:0] pitch_lat_q, pitch_lat_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic             spk_q, spk_d;
  logic             active_q, active_d;
  logic             pd_q, pd_d;

  logic             load;
  logic             terminal;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_sh;
  logic [CNT_W-1:0] hi_time;
  logic             valid;

  // Full-width product, then /32 and truncate: volume 15 gives 15/32 duty.
  assign prod    = {{VOL_W{1'b0}}, pitch} * {{CNT_W{1'b0}}, volume};
  assign prod_sh = prod >> 5;
  assign hi_time = prod_sh[CNT_W-1:0];
  assign valid   = (pitch >= MIN_P);

  tone_period_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .enable_i  (state_q != IDLE),
    .load_val_i(pitch_lat_q),
    .cnt_o     (cnt),
    .cnt_next_o(cnt_next),
    .terminal_o(terminal)
  );

  // Next-state: new settings are accepted only from IDLE or on the last
  // cycle of a period, so a running period is never cut short.
  always_comb begin
    state_d     = state_q;
    pitch_lat_d = pitch_lat_q;
    hi_lat_d    = hi_lat_q;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && valid) begin
          load        = 1'b1;
          pitch_lat_d = pitch;
          hi_lat_d    = hi_time;
          state_d     = RUN;
        end
      end
      RUN, DRAIN: begin
        if (terminal) begin
          if (en && valid) begin
            load        = 1'b1;
            pitch_lat_d = pitch;
            hi_lat_d    = hi_time;
            state_d     = RUN;
          end else begin
            // Clearing the latches keeps cur_pitch at 0 while idle.
            pitch_lat_d = '0;
            hi_lat_d    = '0;
            state_d     = IDLE;
          end
        end else if (state_q == RUN && !en) begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next count and latches, then registered.
  always_comb begin
    active_d = (state_d != IDLE);
    spk_d    = active_d && (cnt_next < hi_lat_d);
    pd_d     = active_d && (cnt_next == pitch_lat_d - ONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pitch_lat_q <= '0;
      hi_lat_q    <= '0;
      spk_q       <= 1'b0;
      active_q    <= 1'b0;
      pd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pitch_lat_q <= pitch_lat_d;
      hi_lat_q    <= hi_lat_d;
      spk_q       <= spk_d;
      active_q    <= active_d;
      pd_q        <= pd_d;
    end
  end

  assign spk_out     = spk_q;
  assign active      = active_q;
  assign period_done = pd_q;
  assign cur_pitch   = pitch_lat_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - self-checking bench for tone_gen
module tb_tone_gen;

  localparam int CNT_W = 22;
  localparam int VOL_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] pitch;
  logic [VOL_W-1:0] volume;
  logic             spk_out;
  logic             active;
  logic             period_done;
  logic [CNT_W-1:0] cur_pitch;

  always #5 clk = ~clk;

  tone_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pitch      (pitch),
    .volume     (volume),
    .spk_out    (spk_out),
    .active     (active),
    .period_done(period_done),
    .cur_pitch  (cur_pitch)
  );

  typedef struct {
    int period;
    int hi;
  } exp_t;

  typedef struct {
    int pitch;
    int vol;
    int hi;
    int nper;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Period monitor: measures each completed period and compares it against
  // the expectation queued when the stimulus was driven.
  int   m_cyc;
  int   m_hi;
  bit   m_prev;
  bit   m_bad;
  exp_t m_e;
  initial begin
    m_cyc = 0; m_hi = 0; m_prev = 0; m_bad = 0;
    forever begin
      @(negedge clk);
      if (rst || !active) begin
        m_cyc = 0; m_hi = 0; m_prev = 0; m_bad = 0;
      end else begin
        m_cyc++;
        if (spk_out) begin
          if (m_cyc > 1 && !m_prev) m_bad = 1;
          m_hi++;
        end
        m_prev = spk_out;
        if (period_done) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_period: got period %0d hi %0d, required no period", m_cyc, m_hi);
          end else begin
            m_e = sb.pop_front();
            if (m_cyc != m_e.period || m_hi != m_e.hi || m_bad || int'(cur_pitch) != m_e.period) begin
              n_err++;
              $display("FAIL period_shape: got period %0d hi %0d rise_mid %0d cur_pitch %0d, required period %0d hi %0d rise_mid 0",
                       m_cyc, m_hi, m_bad, cur_pitch, m_e.period, m_e.hi);
            end
          end
          m_cyc = 0; m_hi = 0; m_prev = 0; m_bad = 0;
        end
      end
    end
  end

  task automatic wait_pd(input int n);
    int b;
    for (int k = 0; k < n; k++) begin
      b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!period_done && b < 300);
      if (!period_done) begin
        n_vec++;
        n_err++;
        $display("FAIL pd_timeout: got no period_done in %0d cycles, required one", b);
      end
    end
  endtask

  task automatic run_tone(input vec_t v);
    for (int k = 0; k < v.nper; k++) sb.push_back('{v.pitch, v.hi});
    pitch  = CNT_W'(v.pitch);
    volume = VOL_W'(v.vol);
    en     = 1'b1;
    wait_pd(v.nper - 1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_pd(1);
    @(negedge clk);
    check("idle_after_drain", int'(active), 0);
    check("spk_idle", int'(spk_out), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got no finish, required finish within 70000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int h;

    // pitch, volume, expected high cycles, periods to play
    tbl[0] = '{32, 8, 8, 3};
    tbl[1] = '{20, 15, 9, 2};
    tbl[2] = '{32, 0, 0, 2};
    tbl[3] = '{4, 15, 1, 3};
    tbl[4] = '{5, 7, 1, 2};
    tbl[5] = '{40, 15, 18, 2};
    tbl[6] = '{100, 4, 12, 1};
    tbl[7] = '{7, 3, 0, 2};

    rst = 1'b1; en = 1'b0; pitch = '0; volume = '0;
    #1;
    check("reset_spk", int'(spk_out), 0);
    check("reset_active", int'(active), 0);
    check("reset_pd", int'(period_done), 0);
    check("reset_cur_pitch", int'(cur_pitch), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'(active), 0);

    // Pitch below the minimum never starts a tone.
    pitch = 3; volume = 8; en = 1'b1; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (active || spk_out || cur_pitch != 0) bad = 1;
    end
    check("invalid_pitch_idle", int'(bad), 0);
    en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_tone(tbl[i]);

    // Mid-period pitch/volume change applies only at the next boundary.
    sb.push_back('{32, 8});
    sb.push_back('{20, 9});
    pitch = 32; volume = 8; en = 1'b1;
    repeat (11) @(negedge clk);
    pitch = 20; volume = 15;
    wait_pd(1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_pd(1);
    @(negedge clk);
    check("update_idle", int'(active), 0);

    // Drain with en reasserted mid-drain: seamless continuation.
    sb.push_back('{32, 8});
    sb.push_back('{32, 8});
    pitch = 32; volume = 8; en = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("drain_active", int'(active), 1);
    repeat (14) @(negedge clk);
    en = 1'b1;
    wait_pd(1);
    @(negedge clk);
    check("reassert_active", int'(active), 1);
    check("reassert_spk", int'(spk_out), 1);
    @(negedge clk);
    en = 1'b0;
    wait_pd(1);
    @(negedge clk);
    check("reassert_idle", int'(active), 0);

    // en falls exactly at the boundary edge: straight to IDLE, no drain.
    sb.push_back('{32, 8});
    en = 1'b1;
    wait_pd(1);
    en = 1'b0;
    @(negedge clk);
    check("boundary_fall_idle", int'(active), 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (active || period_done || spk_out) bad = 1;
    end
    check("no_extra_period", int'(bad), 0);

    // Asynchronous reset mid-tone, then a fresh start.
    en = 1'b1;
    repeat (14) @(negedge clk);
    check("pre_reset_cur_pitch", int'(cur_pitch), 32);
    #1 rst = 1'b1;
    #1;
    check("async_rst_spk", int'(spk_out), 0);
    check("async_rst_active", int'(active), 0);
    check("async_rst_pd", int'(period_done), 0);
    check("async_rst_cur_pitch", int'(cur_pitch), 0);
    sb.push_back('{32, 8});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_spk", int'(spk_out), 1);
    check("restart_active", int'(active), 1);
    @(negedge clk);
    en = 1'b0;
    wait_pd(1);
    @(negedge clk);
    check("restart_idle", int'(active), 0);

    // Real note: si at full volume.
    pitch = 101215; volume = 15; en = 1'b1;
    @(negedge clk);
    check("si_cur_pitch", int'(cur_pitch), 101215);
    h = 0;
    while (spk_out && h < 60000) begin
      h++;
      @(negedge clk);
    end
    check("si_high_cycles", h, 47444);
    check("si_active", int'(active), 1);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("si_abort_idle", int'(active), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
